// File: rtl/hazard_stall_unit.sv
// Stall/flush generator for the 5-stage pipeline: load-use stalls, branch flushes
// and whole-pipe freezes while data memory is busy, plus saturating event counters.
module hazard_stall_unit #(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ifid_rs_i,
  input  logic [3:0]       ifid_rt_i,
  input  logic             ifid_uses_rs_i,
  input  logic             ifid_uses_rt_i,
  input  logic [3:0]       idex_wr_i,
  input  logic             idex_memread_i,
  input  logic             idex_regwrite_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_freeze_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o,
  output logic             dbg_state_o
);

  typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

  localparam logic [3:0] LU_RELOAD = 4'(LOAD_USE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             flush_pending_q, flush_pending_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             lu;
  logic             flush_evt;

  // R0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign lu = idex_memread_i & idex_regwrite_i & (idex_wr_i != 4'd0) &
              ((ifid_uses_rs_i & (ifid_rs_i == idex_wr_i)) |
               (ifid_uses_rt_i & (ifid_rt_i == idex_wr_i)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      cnt_q           <= 4'd0;
      flush_pending_q <= 1'b0;
      stall_cycles_q  <= '0;
      flush_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
      stall_cycles_q  <= stall_cycles_d;
      flush_count_q   <= flush_count_d;
    end
  end

  // Priority: reset > freeze > flush > load-use stall > normal.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    flush_pending_d = flush_pending_q;
    flush_evt       = 1'b0;
    pc_write_o      = 1'b1;
    ifid_write_o    = 1'b1;
    ifid_flush_o    = 1'b0;
    idex_bubble_o   = 1'b0;
    pipe_freeze_o   = 1'b0;
    if (rst) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (mem_busy_i) begin
      // A branch resolved while frozen is remembered and applied on unfreeze.
      pipe_freeze_o = 1'b1;
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      if (branch_taken_i) flush_pending_d = 1'b1;
    end else if (branch_taken_i || flush_pending_q) begin
      ifid_flush_o    = 1'b1;
      idex_bubble_o   = 1'b1;
      flush_pending_d = 1'b0;
      state_d         = RUN;
      cnt_d           = 4'd0;
      flush_evt       = 1'b1;
    end else if (state_q == LU_STALL) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      cnt_d         = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = RUN;
    end else if (lu) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      if (LOAD_USE_CYCLES > 1) begin
        state_d = LU_STALL;
        cnt_d   = LU_RELOAD;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_write_o && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (flush_evt && (flush_count_q != {CNT_W{1'b1}}))
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
  assign dbg_state_o    = state_q;

endmodule
